event_profiler_array: RTL

Parametrised N-channel event profiler, the successor to the fixed icache/dcache profiler.
- Each channel counts either rising edges (events) or high cycles (latency) of a 1-bit probe.
- Counters are free-running while enabled. A coherent snapshot of all channels is published every SNAPSHOT_PERIOD cycles, or on software request.
- Sits beside the CPU core; probes come from cache and pipeline status lines, and snapshots are read over the profiler register bus.

---
 rtl/profiler_pkg.sv | 10 +
 rtl/profiler_channel.sv | 50 +++++
 rtl/event_profiler_array.sv | 68 ++++++
 3 files changed

// File: rtl/profiler_pkg.sv
// Shared types and constants for the event profiler array.
// Optional build macro PROFILER_SATURATE_EN (saturating counters) is consumed by profiler_channel.
package profiler_pkg;

    typedef enum logic {MODE_EDGE = 1'b0, MODE_LEVEL = 1'b1} prof_mode_t;

    localparam int CLOCK_FREQ = 100_000_000;
    localparam int SNAP_CNT_W = 16;

endpackage

// File: rtl/profiler_channel.sv
// One profiler channel: counts probe rising edges (EDGE) or high cycles (LEVEL), sticky overflow.
// Build macro PROFILER_SATURATE_EN: counter saturates at all-ones instead of wrapping.
module profiler_channel #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             probe,
    input  logic             mode,
    output logic [CNT_W-1:0] cnt,
    output logic             overflow
);
    import profiler_pkg::*;

    logic probe_prev;
    logic hit;
    logic at_max;

    assign at_max = (cnt == {CNT_W{1'b1}});
    assign hit    = (prof_mode_t'(mode) == MODE_LEVEL) ? probe : (probe & ~probe_prev);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            probe_prev <= 1'b0;
            overflow   <= 1'b0;
        end else if (!enable) begin
            cnt        <= '0;
            probe_prev <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            probe_prev <= probe;
            if (hit) begin
                // Flag fires on the increment that wraps, or on the first one blocked at max.
                if (at_max) begin
                    overflow <= 1'b1;
                end
`ifdef PROFILER_SATURATE_EN
                if (!at_max) begin
                    cnt <= cnt + CNT_W'(1);
                end
`else
                cnt <= cnt + CNT_W'(1);
`endif
            end
        end
    end

endmodule

// File: rtl/event_profiler_array.sv
// N-channel event profiler: free-running per-channel counters, periodic or requested coherent snapshots.
// Build macro PROFILER_SATURATE_EN selects saturating rather than wrapping counters.
module event_profiler_array #(
    parameter int NUM_CH          = 8,
    parameter int CNT_W           = 32,
    parameter int CLOCK_FREQ      = profiler_pkg::CLOCK_FREQ,
    parameter int SNAPSHOT_PERIOD = 2 * CLOCK_FREQ
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [NUM_CH-1:0]                   probe,
    input  logic [NUM_CH-1:0]                   ch_mode,
    input  logic                                snap_req,
    output logic [NUM_CH*CNT_W-1:0]             snap_data,
    output logic                                snap_valid,
    output logic [profiler_pkg::SNAP_CNT_W-1:0] snap_count,
    output logic [NUM_CH-1:0]                   overflow
);
    import profiler_pkg::*;

    localparam int TW = (SNAPSHOT_PERIOD > 1) ? $clog2(SNAPSHOT_PERIOD) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(SNAPSHOT_PERIOD - 1);

    logic [TW-1:0]           timer;
    logic [NUM_CH*CNT_W-1:0] cnt_all;
    logic                    fire;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        profiler_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable),
            .probe   (probe[k]),
            .mode    (ch_mode[k]),
            .cnt     (cnt_all[k*CNT_W +: CNT_W]),
            .overflow(overflow[k])
        );
    end

    // A request coinciding with the timer terminal count still yields a single snapshot.
    assign fire = enable & ((timer == T_LAST) | snap_req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer      <= '0;
            snap_data  <= '0;
            snap_valid <= 1'b0;
            snap_count <= '0;
        end else if (!enable) begin
            timer      <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= fire;
            if (fire) begin
                // Counter outputs are registered, so this captures the pre-increment values.
                timer      <= '0;
                snap_data  <= cnt_all;
                snap_count <= snap_count + SNAP_CNT_W'(1);
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule
